// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register of the 5-stage MIPS core. It also does load-use
// hazard detection, inserts bubbles and squashes on a branch/jump flush.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-low reset
//   IfIdRs/Rt/Rd              register fields of the instruction in ID
//   IfIdData1/Data2/Imm       register-file read data, sign-extended immediate
//   *In                       decoded control for the instruction in ID
//   flush                     branch/jump taken in ID; squash what is latched
//   IdExRs/Rt/Rd              registered register fields (Rs/Rt to forwarding)
//   IdExData1/Data2/Imm       registered operands
//   IdExWriteReg              registered destination (regDst ? Rd : Rt)
//   regWrite..aluOp           registered control to EX
//   pcWrite, ifIdWrite        combinational front-end enables (0 = hold)
//   stall                     combinational load-use hazard indication
//   stallCount                registered saturating count of stall cycles
//
// Handshake: there is no valid/ready pair here. The front end is held by
// pcWrite/ifIdWrite = 0 for exactly the cycles in which stall = 1; the
// instruction held in IF/ID is then captured at the first edge where stall
// and flush are both 0.
// -----------------------------------------------------------------------------
module id_ex_stage #(
  // Width of the stall counter; it saturates at all-ones.
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         IfIdRs,
  input  logic [4:0]         IfIdRt,
  input  logic [4:0]         IfIdRd,
  input  logic [31:0]        IfIdData1,
  input  logic [31:0]        IfIdData2,
  input  logic [31:0]        IfIdImm,
  input  logic               regWriteIn,
  input  logic               memReadIn,
  input  logic               memWriteIn,
  input  logic               memToRegIn,
  input  logic               aluSrcIn,
  input  logic               regDstIn,
  input  logic [2:0]         aluOpIn,
  input  logic               flush,
  output logic [4:0]         IdExRs,
  output logic [4:0]         IdExRt,
  output logic [4:0]         IdExRd,
  output logic [31:0]        IdExData1,
  output logic [31:0]        IdExData2,
  output logic [31:0]        IdExImm,
  output logic [4:0]         IdExWriteReg,
  output logic               regWrite,
  output logic               memRead,
  output logic               memWrite,
  output logic               memToReg,
  output logic               aluSrc,
  output logic [2:0]         aluOp,
  output logic               pcWrite,
  output logic               ifIdWrite,
  output logic               stall,
  output logic [COUNT_W-1:0] stallCount
);

  // A load in ID/EX whose destination is read by the instruction in IF/ID.
  // Only registered ID/EX state and the live IF/ID fields feed this, so there
  // is no path from the *In control inputs to stall. A load to $0 never
  // stalls because $0 is never really written.
  assign stall = memRead & (IdExRt != 5'd0) &
                 ((IdExRt == IfIdRs) | (IdExRt == IfIdRt));

  // Front end holds while the hazard is present. A coinciding flush does not
  // override this: the PC redirect is owned by the upstream flush logic.
  assign pcWrite   = ~stall;
  assign ifIdWrite = ~stall;

  // Reset, flush and stall all leave an all-zero register. Zeroing the
  // register fields and data too means the forwarding unit can never match a
  // bubble, not just that the bubble has no side effects.
  always_ff @(posedge clk) begin
    if (!rst || flush || stall) begin
      IdExRs       <= 5'd0;
      IdExRt       <= 5'd0;
      IdExRd       <= 5'd0;
      IdExData1    <= 32'd0;
      IdExData2    <= 32'd0;
      IdExImm      <= 32'd0;
      IdExWriteReg <= 5'd0;
      regWrite     <= 1'b0;
      memRead      <= 1'b0;
      memWrite     <= 1'b0;
      memToReg     <= 1'b0;
      aluSrc       <= 1'b0;
      aluOp        <= 3'd0;
    end else begin
      IdExRs       <= IfIdRs;
      IdExRt       <= IfIdRt;
      IdExRd       <= IfIdRd;
      IdExData1    <= IfIdData1;
      IdExData2    <= IfIdData2;
      IdExImm      <= IfIdImm;
      // Destination is resolved at capture time from the incoming regDst.
      IdExWriteReg <= regDstIn ? IfIdRd : IfIdRt;
      regWrite     <= regWriteIn;
      memRead      <= memReadIn;
      memWrite     <= memWriteIn;
      memToReg     <= memToRegIn;
      aluSrc       <= aluSrcIn;
      aluOp        <= aluOpIn;
    end
  end

  // Counts every stall edge, including those that coincide with a flush.
  // Cleared only by reset; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stallCount <= '0;
    end else if (stall && (stallCount != {COUNT_W{1'b1}})) begin
      stallCount <= stallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int W = 124;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic [4:0]  if_id_rs, if_id_rt, if_id_rd;
  logic [31:0] if_id_data1, if_id_data2, if_id_imm;
  logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
  logic        alu_src_in, reg_dst_in, flush;
  logic [2:0]  alu_op_in;

  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_write_reg;
  logic [31:0] id_ex_data1, id_ex_data2, id_ex_imm;
  logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src;
  logic [2:0]  alu_op;
  logic        pc_write, if_id_write, stall;
  logic [15:0] stall_count;

  // narrow-counter instance sharing the same inputs
  logic [4:0]  s_rs, s_rt, s_rd, s_write_reg;
  logic [31:0] s_data1, s_data2, s_imm;
  logic        s_reg_write, s_mem_read, s_mem_write, s_mem_to_reg, s_alu_src;
  logic [2:0]  s_alu_op;
  logic        s_pc_write, s_if_id_write, s_stall;
  logic [3:0]  s_count;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .IfIdRs(if_id_rs), .IfIdRt(if_id_rt), .IfIdRd(if_id_rd),
    .IfIdData1(if_id_data1), .IfIdData2(if_id_data2), .IfIdImm(if_id_imm),
    .regWriteIn(reg_write_in), .memReadIn(mem_read_in), .memWriteIn(mem_write_in),
    .memToRegIn(mem_to_reg_in), .aluSrcIn(alu_src_in), .regDstIn(reg_dst_in),
    .aluOpIn(alu_op_in), .flush(flush),
    .IdExRs(id_ex_rs), .IdExRt(id_ex_rt), .IdExRd(id_ex_rd),
    .IdExData1(id_ex_data1), .IdExData2(id_ex_data2), .IdExImm(id_ex_imm),
    .IdExWriteReg(id_ex_write_reg),
    .regWrite(reg_write), .memRead(mem_read), .memWrite(mem_write),
    .memToReg(mem_to_reg), .aluSrc(alu_src), .aluOp(alu_op),
    .pcWrite(pc_write), .ifIdWrite(if_id_write), .stall(stall),
    .stallCount(stall_count)
  );

  id_ex_stage #(.COUNT_W(4)) sat_dut (
    .clk(clk), .rst(rst),
    .IfIdRs(if_id_rs), .IfIdRt(if_id_rt), .IfIdRd(if_id_rd),
    .IfIdData1(if_id_data1), .IfIdData2(if_id_data2), .IfIdImm(if_id_imm),
    .regWriteIn(reg_write_in), .memReadIn(mem_read_in), .memWriteIn(mem_write_in),
    .memToRegIn(mem_to_reg_in), .aluSrcIn(alu_src_in), .regDstIn(reg_dst_in),
    .aluOpIn(alu_op_in), .flush(flush),
    .IdExRs(s_rs), .IdExRt(s_rt), .IdExRd(s_rd),
    .IdExData1(s_data1), .IdExData2(s_data2), .IdExImm(s_imm),
    .IdExWriteReg(s_write_reg),
    .regWrite(s_reg_write), .memRead(s_mem_read), .memWrite(s_mem_write),
    .memToReg(s_mem_to_reg), .aluSrc(s_alu_src), .aluOp(s_alu_op),
    .pcWrite(s_pc_write), .ifIdWrite(s_if_id_write), .stall(s_stall),
    .stallCount(s_count)
  );

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  int           pass_cnt = 0;
  int           total_cnt = 0;
  logic         m_mem_read;   // model of registered memRead
  logic [4:0]   m_rt;         // model of registered IdExRt
  logic [15:0]  m_cnt;        // model of 16-bit stall counter
  logic [3:0]   m_sat;        // model of 4-bit stall counter

  function automatic logic [W-1:0] obs_vec();
    return {id_ex_rs, id_ex_rt, id_ex_rd, id_ex_data1, id_ex_data2, id_ex_imm,
            id_ex_write_reg, reg_write, mem_read, mem_write, mem_to_reg,
            alu_src, alu_op};
  endfunction

  function automatic logic model_stall();
    return m_mem_read && (m_rt != 5'd0) &&
           ((m_rt == if_id_rs) || (m_rt == if_id_rt));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] imm,
                           input logic rdst, input logic rw, input logic mr,
                           input logic mw, input logic mtr, input logic as,
                           input logic [2:0] aop, input logic fl);
    if_id_rs = rs; if_id_rt = rt; if_id_rd = rd;
    if_id_data1 = d1; if_id_data2 = d2; if_id_imm = imm;
    reg_dst_in = rdst; reg_write_in = rw; mem_read_in = mr;
    mem_write_in = mw; mem_to_reg_in = mtr; alu_src_in = as;
    alu_op_in = aop; flush = fl;
    #1;
  endtask

  // Push the expected ID/EX contents for the coming edge, advance the model,
  // then clock and settle.
  task automatic step();
    logic         st;
    logic [W-1:0] e;
    st = model_stall();
    if (!rst || flush || st) e = '0;
    else e = {if_id_rs, if_id_rt, if_id_rd, if_id_data1, if_id_data2, if_id_imm,
              (reg_dst_in ? if_id_rd : if_id_rt), reg_write_in, mem_read_in,
              mem_write_in, mem_to_reg_in, alu_src_in, alu_op_in};
    exp_q.push_back(e);
    if (!rst) begin
      m_cnt = 16'd0;
      m_sat = 4'd0;
    end else if (st) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_sat != 4'hF) m_sat = m_sat + 4'd1;
    end
    if (e == '0) begin
      m_mem_read = 1'b0;
      m_rt = 5'd0;
    end else begin
      m_mem_read = mem_read_in;
      m_rt = if_id_rt;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] e;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_instr(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      step();
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_vec() !== e) $display("FAIL reset_regs: got %h expected %h", obs_vec(), e);
      else pass_cnt++;
    end
    total_cnt++;
    if (stall_count !== 16'd0) $display("FAIL reset_count: got %h expected 0", stall_count);
    else pass_cnt++;
    total_cnt++;
    if (stall !== 1'b0 || pc_write !== 1'b1 || if_id_write !== 1'b1)
      $display("FAIL reset_enables: got stall=%b pc=%b ifid=%b expected 0 1 1",
               stall, pc_write, if_id_write);
    else pass_cnt++;
    rst = 1'b1;
  endtask

  task automatic test_pass_through();
    logic [W-1:0] e;
    set_instr(5'd8, 5'd9, 5'd10, 32'h5, 32'h7, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0, 3'b010, 1'b0);
    step();
    e = exp_q.pop_front();
    total_cnt++;
    if (obs_vec() !== e) $display("FAIL pass_vec: got %h expected %h", obs_vec(), e);
    else pass_cnt++;
    total_cnt++;
    if (id_ex_rs !== 5'd8 || id_ex_rt !== 5'd9 || id_ex_write_reg !== 5'd10 ||
        reg_write !== 1'b1 || alu_op !== 3'd2 || id_ex_data1 !== 32'h5 ||
        id_ex_data2 !== 32'h7)
      $display("FAIL pass_fields: got rs=%0d rt=%0d wr=%0d rw=%b op=%0d d1=%h d2=%h expected 8 9 10 1 2 5 7",
               id_ex_rs, id_ex_rt, id_ex_write_reg, reg_write, alu_op,
               id_ex_data1, id_ex_data2);
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    logic [W-1:0] e;
    logic [15:0]  cnt0;
    cnt0 = stall_count;
    // lw $9, 0x10($1)
    set_instr(5'd1, 5'd9, 5'd0, 32'h100, 32'h0, 32'h10, 1'b0, 1'b1, 1'b1, 1'b0,
              1'b1, 1'b1, 3'b000, 1'b0);
    step();
    e = exp_q.pop_front();
    total_cnt++;
    if (obs_vec() !== e || id_ex_write_reg !== 5'd9)
      $display("FAIL lu_load: got %h expected %h", obs_vec(), e);
    else pass_cnt++;
    // add $3, $9, $2 (dependent)
    set_instr(5'd9, 5'd2, 5'd3, 32'h11, 32'h22, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0, 3'b010, 1'b0);
    total_cnt++;
    if (stall !== 1'b1 || pc_write !== 1'b0 || if_id_write !== 1'b0)
      $display("FAIL lu_stall: got stall=%b pc=%b ifid=%b expected 1 0 0",
               stall, pc_write, if_id_write);
    else pass_cnt++;
    step();
    e = exp_q.pop_front();
    total_cnt++;
    if (obs_vec() !== e || obs_vec() !== '0)
      $display("FAIL lu_bubble: got %h expected %h", obs_vec(), e);
    else pass_cnt++;
    total_cnt++;
    if (stall_count !== cnt0 + 16'd1)
      $display("FAIL lu_count: got %0d expected %0d", stall_count, cnt0 + 16'd1);
    else pass_cnt++;
    total_cnt++;
    if (stall !== 1'b0 || pc_write !== 1'b1)
      $display("FAIL lu_release: got stall=%b pc=%b expected 0 1", stall, pc_write);
    else pass_cnt++;
    step();
    e = exp_q.pop_front();
    total_cnt++;
    if (obs_vec() !== e || id_ex_rs !== 5'd9 || id_ex_write_reg !== 5'd3)
      $display("FAIL lu_capture: got %h expected %h", obs_vec(), e);
    else pass_cnt++;
  endtask

  task automatic test_no_false_stall();
    logic [W-1:0] e;
    // lw $0 then reader of $0
    set_instr(5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b1, 1'b1, 1'b0,
              1'b1, 1'b1, 3'b000, 1'b0);
    step();
    e = exp_q.pop_front();
    set_instr(5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0, 3'b010, 1'b0);
    total_cnt++;
    if (stall !== 1'b0 || pc_write !== 1'b1)
      $display("FAIL nfs_r0: got stall=%b pc=%b expected 0 1", stall, pc_write);
    else pass_cnt++;
    // lw $9 then independent reader of $3/$4
    set_instr(5'd1, 5'd9, 5'd0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b1, 1'b1, 1'b0,
              1'b1, 1'b1, 3'b000, 1'b0);
    step();
    e = exp_q.pop_front();
    total_cnt++;
    if (obs_vec() !== e) $display("FAIL nfs_load: got %h expected %h", obs_vec(), e);
    else pass_cnt++;
    set_instr(5'd3, 5'd4, 5'd5, 32'h3, 32'h4, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0, 3'b010, 1'b0);
    total_cnt++;
    if (stall !== 1'b0 || if_id_write !== 1'b1)
      $display("FAIL nfs_indep: got stall=%b ifid=%b expected 0 1", stall, if_id_write);
    else pass_cnt++;
    step();
    e = exp_q.pop_front();
    total_cnt++;
    if (obs_vec() !== e) $display("FAIL nfs_capture: got %h expected %h", obs_vec(), e);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    logic [W-1:0] e;
    logic [15:0]  cnt0;
    cnt0 = stall_count;
    // valid instruction squashed
    set_instr(5'd6, 5'd7, 5'd8, 32'hAA, 32'hBB, 32'hCC, 1'b1, 1'b1, 1'b0, 1'b1,
              1'b0, 1'b1, 3'b110, 1'b1);
    step();
    e = exp_q.pop_front();
    total_cnt++;
    if (obs_vec() !== e || obs_vec() !== '0)
      $display("FAIL flush_valid: got %h expected %h", obs_vec(), e);
    else pass_cnt++;
    total_cnt++;
    if (stall_count !== cnt0) $display("FAIL flush_nocount: got %0d expected %0d", stall_count, cnt0);
    else pass_cnt++;
    // pending stall together with flush
    set_instr(5'd1, 5'd12, 5'd0, 32'h0, 32'h0, 32'h8, 1'b0, 1'b1, 1'b1, 1'b0,
              1'b1, 1'b1, 3'b000, 1'b0);
    step();
    e = exp_q.pop_front();
    set_instr(5'd2, 5'd12, 5'd13, 32'h1, 32'h2, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0, 3'b010, 1'b1);
    total_cnt++;
    if (stall !== 1'b1 || pc_write !== 1'b0)
      $display("FAIL flush_stall_en: got stall=%b pc=%b expected 1 0", stall, pc_write);
    else pass_cnt++;
    step();
    e = exp_q.pop_front();
    total_cnt++;
    if (obs_vec() !== e || obs_vec() !== '0)
      $display("FAIL flush_stall_bubble: got %h expected %h", obs_vec(), e);
    else pass_cnt++;
    total_cnt++;
    if (stall_count !== cnt0 + 16'd1)
      $display("FAIL flush_stall_count: got %0d expected %0d", stall_count, cnt0 + 16'd1);
    else pass_cnt++;
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    // lw $9 ; lw $10, 0($9) ; add $11, $10, $0
    set_instr(5'd1, 5'd9, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0,
              1'b1, 1'b1, 3'b000, 1'b0);
    step();
    e = exp_q.pop_front();
    set_instr(5'd9, 5'd10, 5'd0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0,
              1'b1, 1'b1, 3'b000, 1'b0);
    total_cnt++;
    if (stall !== 1'b1) $display("FAIL b2b_stall1: got %b expected 1", stall);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      step();
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_vec() !== e) $display("FAIL b2b_seq%0d: got %h expected %h", i, obs_vec(), e);
      else pass_cnt++;
    end
    set_instr(5'd10, 5'd0, 5'd11, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0, 3'b010, 1'b0);
    total_cnt++;
    if (stall !== 1'b1 || if_id_write !== 1'b0)
      $display("FAIL b2b_stall2: got stall=%b ifid=%b expected 1 0", stall, if_id_write);
    else pass_cnt++;
    step();
    e = exp_q.pop_front();
    step();
    e = exp_q.pop_front();
    total_cnt++;
    if (obs_vec() !== e) $display("FAIL b2b_final: got %h expected %h", obs_vec(), e);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    logic         es;
    for (int i = 0; i < 60; i++) begin
      set_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 5) == 0));
      es = model_stall();
      total_cnt++;
      if (stall !== es || pc_write !== !es)
        $display("FAIL rand_stall%0d: got stall=%b pc=%b expected stall=%b", i, stall, pc_write, es);
      else pass_cnt++;
      step();
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL rand_queue%0d: got empty queue expected entry", i);
      end else begin
        e = exp_q.pop_front();
        total_cnt++;
        if (obs_vec() !== e || stall_count !== m_cnt)
          $display("FAIL rand%0d: got %h cnt=%0d expected %h cnt=%0d", i, obs_vec(), stall_count, e, m_cnt);
        else pass_cnt++;
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_saturation();
    logic [W-1:0] e;
    rst = 1'b0;
    step();
    e = exp_q.pop_front();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_instr(5'd20, 5'd9, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0,
                1'b1, 1'b1, 3'b000, 1'b0);
      step();
      e = exp_q.pop_front();
      set_instr(5'd9, 5'd21, 5'd22, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
                1'b0, 1'b0, 3'b010, 1'b0);
      step();
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_vec() !== e) $display("FAIL sat_bubble%0d: got %h expected %h", i, obs_vec(), e);
      else pass_cnt++;
    end
    total_cnt++;
    if (stall_count !== m_cnt || m_cnt != 16'd20)
      $display("FAIL sat_wide: got %0d expected %0d", stall_count, m_cnt);
    else pass_cnt++;
    total_cnt++;
    if (s_count !== 4'hF) $display("FAIL sat_hold: got %h expected f", s_count);
    else pass_cnt++;
    // reset while a stall is pending
    set_instr(5'd20, 5'd9, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0,
              1'b1, 1'b1, 3'b000, 1'b0);
    step();
    e = exp_q.pop_front();
    set_instr(5'd9, 5'd21, 5'd22, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0, 3'b010, 1'b0);
    rst = 1'b0;
    step();
    e = exp_q.pop_front();
    total_cnt++;
    if (obs_vec() !== e || stall_count !== 16'd0 || s_count !== 4'd0)
      $display("FAIL sat_reset: got %h cnt=%0d sat=%0d expected %h 0 0", obs_vec(), stall_count, s_count, e);
    else pass_cnt++;
    rst = 1'b1;
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    m_mem_read = 1'b0;
    m_rt = 5'd0;
    m_cnt = 16'd0;
    m_sat = 4'd0;
    rst = 1'b0;
    set_instr(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_false_stall();
    test_flush();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
